// File: rtl/fft_out_serializer.sv
// Captures the FFT result bus on a rising fft_finish and streams its N words over valid/ready.
// Optional build macro FFT_OUT_BITREV_EN emits words in bit-reversed bus order (natural bins).
module fft_out_serializer #(
  parameter int unsigned N   = 16,
  parameter int unsigned MSB = 16,
  localparam int unsigned W  = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MSB*N-1:0] fft_data,
  input  logic             fft_finish,
  output logic [MSB-1:0]   sample_out,
  output logic [W-1:0]     sample_idx,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             sample_last,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic {StIdle, StStream} state_e;

  state_e             state_q, state_d;
  logic               finish_q;
  logic [MSB*N-1:0]   frame_q, frame_d;
  logic [W-1:0]       pos_q, pos_d;
  logic [MSB-1:0]     out_q, out_d;
  logic [W-1:0]       idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;

  logic               trigger;
  logic               handshake;
  logic               at_last;
  logic [W-1:0]       pos_next;
  logic [W-1:0]       idx_first;
  logic [W-1:0]       idx_next;

  function automatic logic [W-1:0] word_index(input logic [W-1:0] p);
    logic [W-1:0] r;
`ifdef FFT_OUT_BITREV_EN
    for (int i = 0; i < int'(W); i++) begin
      r[i] = p[int'(W) - 1 - i];
    end
`else
    r = p;
`endif
    return r;
  endfunction

  function automatic logic [MSB-1:0] word_at(input logic [MSB*N-1:0] bus, input logic [W-1:0] k);
    return bus[MSB*int'(k) +: MSB];
  endfunction

  assign trigger   = fft_finish & ~finish_q;
  assign handshake = valid_q & sample_ready;
  assign at_last   = (pos_q == W'(N - 1));
  assign pos_next  = pos_q + W'(1);
  assign idx_first = word_index('0);
  assign idx_next  = word_index(pos_next);

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    pos_d     = pos_q;
    out_d     = out_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          // Word 0 comes straight off the bus; the frame register is not loaded yet.
          frame_d = fft_data;
          pos_d   = '0;
          idx_d   = idx_first;
          out_d   = word_at(fft_data, idx_first);
          valid_d = 1'b1;
          state_d = StStream;
        end
      end
      StStream: begin
        if (handshake && !at_last) begin
          pos_d = pos_next;
          idx_d = idx_next;
          out_d = word_at(frame_q, idx_next);
        end else if (handshake && at_last) begin
          if (trigger) begin
            frame_d = fft_data;
            pos_d   = '0;
            idx_d   = idx_first;
            out_d   = word_at(fft_data, idx_first);
          end else begin
            valid_d = 1'b0;
            state_d = StIdle;
          end
        end
        // Any trigger not aligned with the final handshake drops the new frame.
        if (trigger && !(handshake && at_last)) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      finish_q  <= 1'b0;
      frame_q   <= '0;
      pos_q     <= '0;
      out_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      finish_q  <= fft_finish;
      frame_q   <= frame_d;
      pos_q     <= pos_d;
      out_q     <= out_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_out   = out_q;
  assign sample_idx   = idx_q;
  assign sample_valid = valid_q;
  assign sample_last  = valid_q & at_last;
  assign busy         = (state_q == StStream);
  assign overrun      = overrun_q;

endmodule
